// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: waits out cache misses, extracts byte loads and registers the writeback bundle.
// Optional performance counters are enabled by defining MEM_WB_PERF_CNT_EN.
module mem_wb_stage #(
   parameter int MISS_TIMEOUT  = 64,
   parameter bit SIGN_EXT_BYTE = 1'b1
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        in_valid,
   input  logic        flush,
   input  logic        cache_en,
   input  logic        is_load,
   input  logic        b,
   input  logic        hit,
   input  logic [31:0] cache_addr,
   input  logic [31:0] cache_data_out,
   input  logic [31:0] alu_result,
   input  logic [4:0]  dest_reg,
   input  logic        reg_write_en,
   output logic        stall,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [4:0]  wb_dest,
   output logic [31:0] wb_data,
   output logic        miss_error
`ifdef MEM_WB_PERF_CNT_EN
   ,
   output logic [31:0] perf_miss_cnt,
   output logic [31:0] perf_stall_cyc
`endif
);

   localparam int CW = $clog2(MISS_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_MISS_WAIT = 2'd1,
      S_ERROR     = 2'd2
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_wait_cnt;

   logic            w_miss;
   logic            w_stall;
   logic            w_capture;
   logic [7:0]      w_lane;
   logic [31:0]     w_load_data;
   logic [31:0]     w_wb_data_next;
   logic            w_unused_addr;

   assign w_unused_addr = ^cache_addr[31:2];

   assign w_miss    = in_valid & cache_en & ~hit & ~flush;
   assign w_stall   = (r_state == S_ERROR) ? in_valid : w_miss;
   assign w_capture = in_valid & ~flush & ~w_stall;
   // Stall is forced low while reset is held so upstream never freezes on stale state.
   assign stall     = rst_b & w_stall;

   // Big-endian lanes: address offset 0 is the most significant byte.
   always_comb begin
      w_lane = cache_data_out[7:0];
      case (cache_addr[1:0])
         2'd0:    w_lane = cache_data_out[31:24];
         2'd1:    w_lane = cache_data_out[23:16];
         2'd2:    w_lane = cache_data_out[15:8];
         default: w_lane = cache_data_out[7:0];
      endcase
   end

   always_comb begin
      w_load_data = cache_data_out;
      if (b) begin
         if (SIGN_EXT_BYTE) w_load_data = {{24{w_lane[7]}}, w_lane};
         else               w_load_data = {24'd0, w_lane};
      end
      w_wb_data_next = (cache_en & is_load) ? w_load_data : alu_result;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state      <= S_IDLE;
         r_wait_cnt   <= '0;
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_dest      <= '0;
         wb_data      <= '0;
         miss_error   <= 1'b0;
      end else begin
         if (w_capture) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= reg_write_en;
            wb_dest      <= dest_reg;
            wb_data      <= w_wb_data_next;
         end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
         end

         case (r_state)
            S_IDLE, S_MISS_WAIT: begin
               // wait_cnt is 0 in IDLE, so both states share the same count/timeout step.
               if (w_miss) begin
                  if (r_wait_cnt >= CW'(MISS_TIMEOUT - 1)) begin
                     r_state    <= S_ERROR;
                     r_wait_cnt <= CW'(MISS_TIMEOUT);
                     miss_error <= 1'b1;
                  end else begin
                     r_state    <= S_MISS_WAIT;
                     r_wait_cnt <= r_wait_cnt + 1'b1;
                  end
               end else begin
                  r_state    <= S_IDLE;
                  r_wait_cnt <= '0;
               end
            end
            S_ERROR: begin
               r_state <= S_ERROR;
            end
            default: begin
               r_state    <= S_IDLE;
               r_wait_cnt <= '0;
            end
         endcase
      end
   end

`ifdef MEM_WB_PERF_CNT_EN
   logic [31:0] r_perf_miss_cnt;
   logic [31:0] r_perf_stall_cyc;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_perf_miss_cnt  <= '0;
         r_perf_stall_cyc <= '0;
      end else if (r_state != S_ERROR) begin
         if (r_state == S_IDLE && w_miss) r_perf_miss_cnt <= r_perf_miss_cnt + 32'd1;
         if (w_stall)                      r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
      end
   end

   assign perf_miss_cnt  = r_perf_miss_cnt;
   assign perf_stall_cyc = r_perf_stall_cyc;
`endif

endmodule
